// File: rtl/ofm_drain.sv
// ofm_drain: read-side drain of the packed partial-sum output buffer.
//
// Reads word_cnt words starting at base_addr from a synchronous-read buffer
// (one cycle of read latency). Each word is unpacked into four lanes and
// streamed out MSB lane first over a valid/ready interface. The block only
// reads the buffer and has no write port.
//
// State table
//   state | meaning
//   IDLE  | waiting for start
//   RD    | ena/addra presented to the buffer for one cycle
//   WT    | buffer read latency; douta captured into r_word
//   OUT   | streaming the four lanes of r_word
//   FIN   | one-cycle done pulse
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start                request to drain (accepted in IDLE only)
//   base_addr, word_cnt  region to drain, sampled on acceptance
//   busy, done           status: busy through the done cycle, done pulse
//   ena, addra, douta    buffer read port
//   m_valid, m_ready     stream handshake
//   m_data, m_last       unpacked lane, end of region marker

module ofm_drain #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 64,
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_cnt,
    output logic              busy,
    output logic              done,
    output logic              ena,
    output logic [ADDR_W-1:0] addra,
    input  logic [WORD_W-1:0] douta,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last
);

    localparam int LANES   = WORD_W / LANE_W;
    localparam int LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        OUT  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [15:0]          r_rem;
    logic [LANE_CW-1:0]   r_lane;
    logic [WORD_W-1:0]    r_word;

    logic                 w_xfer;
    logic                 w_last_lane;
    logic                 w_last_word;
    logic [WORD_W-1:0]    w_shifted;

    assign w_xfer      = (r_state == OUT) && m_ready;
    assign w_last_lane = (r_lane == LANE_CW'(LANES - 1));
    assign w_last_word = (r_rem == 16'd1);

    // Lane 0 is the most significant slice, so shift the selected lane up to the top.
    assign w_shifted   = r_word << (r_lane * LANE_W);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (word_cnt != 16'd0) ? RD : FIN;
                end
            end
            RD:  w_next = WT;
            WT:  w_next = OUT;
            OUT: begin
                if (w_xfer && w_last_lane) begin
                    w_next = w_last_word ? FIN : RD;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_lane  <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start && (word_cnt != 16'd0)) begin
                        r_addr <= base_addr;
                        r_rem  <= word_cnt;
                    end
                end
                WT: begin
                    r_word <= douta;
                    r_lane <= '0;
                end
                OUT: begin
                    if (w_xfer) begin
                        if (!w_last_lane) begin
                            r_lane <= r_lane + LANE_CW'(1);
                        end else if (!w_last_word) begin
                            r_rem  <= r_rem - 16'd1;
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // addra comes straight from r_addr, which only moves on the edge into RD,
    // so it holds its value whenever ena is low.
    assign ena     = (r_state == RD);
    assign addra   = r_addr;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == FIN);
    assign m_valid = (r_state == OUT);
    assign m_data  = (r_state == OUT) ? w_shifted[WORD_W-1 -: LANE_W] : '0;
    assign m_last  = (r_state == OUT) && w_last_lane && w_last_word;

endmodule

// File: tb/tb_ofm_drain.sv
// Testbench for ofm_drain: directed drains with a scoreboard of expected
// stream beats and expected buffer read addresses, checked by a monitor.

module tb_ofm_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_cnt = '0;
    logic        busy;
    logic        done;
    logic        ena;
    logic [15:0] addra;
    logic [63:0] douta = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_last;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    bit tog    = 1'b0;

    logic [16:0] exp_q[$];
    logic [15:0] addr_q[$];
    logic [63:0] mem [logic [15:0]];

    ofm_drain #(.ADDR_W(16), .WORD_W(64), .LANE_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .busy      (busy),
        .done      (done),
        .ena       (ena),
        .addra     (addra),
        .douta     (douta),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffer model: data one cycle after ena.
    always @(posedge clk) begin
        if (ena) douta <= mem.exists(addra) ? mem[addra] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every read strobe and every stream transfer against the queues.
    initial begin
        logic        stall_prev;
        logic [16:0] stall_val;
        logic [16:0] e;
        stall_prev = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) n_done++;
                if (ena) begin
                    if (addr_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL ena_unexpected: got ena at addr %0h expected no read", addra);
                    end else begin
                        chk("ena_addr", addra, addr_q.pop_front());
                    end
                end
                if (stall_prev && m_valid) chk("stall_stable", {m_last, m_data}, stall_val);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL beat_unexpected: got data %0h last %0b expected no beat", m_data, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {m_last, m_data}, e);
                    end
                end
                stall_prev = m_valid && !m_ready;
                stall_val  = {m_last, m_data};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Ready toggler for the stall scenario.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) m_ready = ~m_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [15:0] a, input bit last_word);
        logic [63:0] w;
        w = mem[a];
        addr_q.push_back(a);
        for (int l = 0; l < 4; l++) begin
            exp_q.push_back({(last_word && l == 3), w[63-16*l -: 16]});
        end
    endtask

    task automatic push_region(input logic [15:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) push_word(base + 16'(i), i == cnt - 1);
    endtask

    // Called at cycle 1 (#1 after the accepting edge); returns cycle of done and first m_valid.
    task automatic wait_done(output int lat, output int fv);
        int k;
        k  = 1;
        fv = -1;
        chk("busy_after_accept", busy, 1'b1);
        while (k <= 400) begin
            if (m_valid && fv < 0) fv = k;
            if (done) break;
            @(posedge clk);
            #1;
            k++;
        end
        if (k > 400) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end else begin
            chk("busy_in_done_cycle", busy, 1'b1);
        end
        lat = k;
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 1'b0);
        chk("busy_cleared", busy, 1'b0);
    endtask

    task automatic run_drain(input logic [15:0] base, input logic [15:0] cnt,
                             output int lat, output int fv);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = base; word_cnt = cnt;
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = 16'h5A5A; word_cnt = 16'h0007;
        wait_done(lat, fv);
    endtask

    initial begin
        int lat, fv, d0;

        mem[16'h0010] = 64'h0001_0002_0003_0004;
        mem[16'h0011] = 64'h0005_0006_0007_0008;
        mem[16'hFFFF] = 64'h8001_7FFF_0000_FFFF;
        mem[16'h0000] = 64'hA5A5_5A5A_1234_FEDC;
        mem[16'h0040] = 64'h1111_2222_3333_4444;
        mem[16'h0041] = 64'h5555_6666_7777_8888;
        mem[16'h0050] = 64'hCAFE_BEEF_0BAD_F00D;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ena", ena, 1'b0);
        chk("rst_addra", addra, 16'h0000);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 16'h0000);
        chk("rst_m_last", m_last, 1'b0);
        rst_n = 1'b1;

        // Basic two-word drain, ready held high
        push_region(16'h0010, 2);
        d0 = n_done;
        run_drain(16'h0010, 16'd2, lat, fv);
        chk("basic_done_latency", lat, 13);
        chk("basic_first_valid_latency", fv, 3);
        chk("basic_done_count", n_done - d0, 1);

        // Same region with ready toggling every cycle
        push_region(16'h0010, 2);
        tog = 1'b1;
        run_drain(16'h0010, 16'd2, lat, fv);
        tog = 1'b0;
        m_ready = 1'b1;
        chk("stall_first_valid_latency", fv, 3);
        chk("stall_queue_drained", exp_q.size(), 0);

        // Address wrap
        push_region(16'hFFFF, 2);
        run_drain(16'hFFFF, 16'd2, lat, fv);
        chk("wrap_done_latency", lat, 13);
        chk("wrap_addr_queue_drained", addr_q.size(), 0);

        // Zero-length drain: no read, no beat, one done
        d0 = n_done;
        run_drain(16'h0030, 16'd0, lat, fv);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_cnt_done_once", n_done - d0, 1);
        chk("zero_cnt_no_valid", fv, -1);

        // Reset while lane 1 of the first word is pending
        addr_q.push_back(16'h0040);
        exp_q.push_back({1'b0, 16'h1111});
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 16'h0040; word_cnt = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_lane1", {m_valid, m_data}, {1'b1, 16'h2222});
        d0 = n_done;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_ena", ena, 1'b0);
        chk("midrst_addra", addra, 16'h0000);
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_m_data", m_data, 16'h0000);
        chk("midrst_m_last", m_last, 1'b0);
        push_region(16'h0050, 1);
        rst_n = 1'b1;
        start = 1'b1; base_addr = 16'h0050; word_cnt = 16'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, fv);
        chk("post_reset_done_latency", lat, 7);
        chk("post_reset_done_count", n_done - d0, 1);

        // Start pulsed while busy must be ignored
        push_region(16'h0010, 2);
        d0 = n_done;
        fork
            run_drain(16'h0010, 16'd2, lat, fv);
            begin
                repeat (4) @(posedge clk);
                #1;
                start = 1'b1; base_addr = 16'h0200; word_cnt = 16'd5;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        chk("busy_start_done_latency", lat, 13);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_start_done_count", n_done - d0, 1);
        chk("busy_start_stays_idle", busy, 1'b0);

        repeat (3) @(posedge clk);
        chk("final_beats_consumed", exp_q.size(), 0);
        chk("final_reads_consumed", addr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
